// File: rtl/fp_cvt_pkg.sv
// Shared codes and helpers for the FP64 convert front-end.
// Type/rounding encodings, flag bit positions, rm and type legality.
package fp_cvt_pkg;

   localparam logic [1:0] TYPE_FP32   = 2'b00;
   localparam logic [1:0] TYPE_FP64   = 2'b01;
   localparam logic [1:0] TYPE_INT32  = 2'b10;
   localparam logic [1:0] TYPE_UINT32 = 2'b11;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef struct packed {
      logic [63:0] operand;
      logic [1:0]  in_type;
      logic [1:0]  out_type;
      logic [2:0]  rm;
      logic        illegal;
      logic        src;
   } cvt_op_t;

   function automatic logic [2:0] resolve_rm(
      input logic [2:0] rm,
      input logic [2:0] frm
   );
      return (rm == RM_DYN) ? frm : rm;
   endfunction

   function automatic logic rm_legal(input logic [2:0] rm);
      return rm <= RM_RMM;
   endfunction

   // Only 32-bit results exist, and same-type moves are not conversions.
   function automatic logic types_legal(
      input logic [1:0] in_type,
      input logic [1:0] out_type
   );
      return (out_type != TYPE_FP64) && (in_type != out_type);
   endfunction

endpackage

// File: rtl/fp_cvt_rr_arb2.sv
// Two-input round-robin arbiter with a one-bit priority pointer.
// Ports: req[1:0] in, advance in (grant taken), gnt[1:0] out.
module fp_cvt_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic rr;

   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = rr ? 2'b10 : 2'b01;
      end
   end

   // Pointer moves to the other requester after any taken grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= 1'b0;
      end else if (advance && (|gnt)) begin
         rr <= ~gnt[1];
      end
   end

endmodule

// File: rtl/fp_convert_sequencer.sv
// Issue/response sequencer in front of the shared FP64 converter.
// Ports: req0/req1 valid-ready issue, cvt_* to converter, rsp_* out, fflags.
module fp_convert_sequencer
   import fp_cvt_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [63:0]      req0_operand,
   input  logic [1:0]       req0_in_type,
   input  logic [1:0]       req0_out_type,
   input  logic [2:0]       req0_rm,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [63:0]      req1_operand,
   input  logic [1:0]       req1_in_type,
   input  logic [1:0]       req1_out_type,
   input  logic [2:0]       req1_rm,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic [2:0]       frm,
   input  logic             flush,
   output logic [63:0]      cvt_operand,
   output logic [1:0]       cvt_in_type,
   output logic [1:0]       cvt_out_type,
   output logic [2:0]       cvt_rm,
   input  logic [31:0]      cvt_result,
   input  logic [3:0]       cvt_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_illegal,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       fflags,
   input  logic             fflags_clr
);

   logic             a_valid;
   cvt_op_t          a_op;
   logic [TAG_W-1:0] a_tag;

   logic             b_valid;
   logic [31:0]      b_result;
   logic [3:0]       b_flags;
   logic             b_illegal;
   logic             b_src;
   logic [TAG_W-1:0] b_tag;

   logic [3:0]       fflags_q;

   logic [1:0]       gnt;
   logic             b_load;
   logic             a_accept;
   logic             take;
   logic             sel;
   logic [2:0]       rm_in;
   logic [2:0]       rm_res;
   cvt_op_t          req_op;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_hs;

   assign b_load   = a_valid && (!b_valid || rsp_ready);
   assign a_accept = !a_valid || b_load;
   assign take     = a_accept && !flush && !rst;

   fp_cvt_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1_valid, req0_valid}),
      .advance (take),
      .gnt     (gnt)
   );

   assign req0_ready = take && gnt[0];
   assign req1_ready = take && gnt[1];

   always_comb begin
      req_op  = '0;
      sel     = gnt[1];
      rm_in   = sel ? req1_rm : req0_rm;
      rm_res  = resolve_rm(rm_in, frm);
      req_tag = sel ? req1_tag : req0_tag;
      req_op.operand  = sel ? req1_operand : req0_operand;
      req_op.in_type  = sel ? req1_in_type : req0_in_type;
      req_op.out_type = sel ? req1_out_type : req0_out_type;
      req_op.rm       = rm_res;
      req_op.src      = sel;
      req_op.illegal  = !rm_legal(rm_res) ||
                        !types_legal(req_op.in_type, req_op.out_type);
   end

   // Stage A: issue register feeding the converter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid <= 1'b0;
         a_op    <= '0;
         a_tag   <= '0;
      end else if (flush) begin
         a_valid <= 1'b0;
      end else if (a_accept) begin
         a_valid <= |gnt;
         if (|gnt) begin
            a_op  <= req_op;
            a_tag <= req_tag;
         end
      end
   end

   // Illegal ops still drive the converter, but with a benign rm.
   always_comb begin
      cvt_operand  = '0;
      cvt_in_type  = '0;
      cvt_out_type = '0;
      cvt_rm       = '0;
      if (a_valid) begin
         cvt_operand  = a_op.operand;
         cvt_in_type  = a_op.in_type;
         cvt_out_type = a_op.out_type;
         cvt_rm       = a_op.illegal ? RM_RTZ : a_op.rm;
      end
   end

   // Stage B: response register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_valid   <= 1'b0;
         b_result  <= '0;
         b_flags   <= '0;
         b_illegal <= 1'b0;
         b_src     <= 1'b0;
         b_tag     <= '0;
      end else begin
         if (flush) begin
            b_valid <= 1'b0;
         end else if (b_load) begin
            b_valid <= 1'b1;
         end else if (rsp_ready) begin
            b_valid <= 1'b0;
         end
         if (b_load && !flush) begin
            b_result  <= a_op.illegal ? '0 : cvt_result;
            b_flags   <= a_op.illegal ? '0 : cvt_flags;
            b_illegal <= a_op.illegal;
            b_src     <= a_op.src;
            b_tag     <= a_tag;
         end
      end
   end

   // Reset blanks the response port in the same cycle.
   assign rsp_valid   = b_valid && !rst;
   assign rsp_result  = rst ? '0 : b_result;
   assign rsp_flags   = rst ? '0 : b_flags;
   assign rsp_illegal = rst ? 1'b0 : b_illegal;
   assign rsp_src     = rst ? 1'b0 : b_src;
   assign rsp_tag     = rst ? '0 : b_tag;

   assign rsp_hs = rsp_valid && rsp_ready && !rsp_illegal;

   // Clear drops old state only; a same-cycle retire still lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= (fflags_clr ? 4'b0 : fflags_q) |
                     (rsp_hs ? rsp_flags : 4'b0);
      end
   end

   assign fflags = fflags_q;

endmodule

// File: tb/tb_fp_convert_sequencer.sv
// Self-checking bench for fp_convert_sequencer.
// Queue-level model of in-flight ops plus directed literal checks.
module tb_fp_convert_sequencer;

   localparam int TAG_W = 4;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [63:0] req0_operand, req1_operand;
   logic [1:0]  req0_in_type, req1_in_type;
   logic [1:0]  req0_out_type, req1_out_type;
   logic [2:0]  req0_rm, req1_rm;
   logic [3:0]  req0_tag, req1_tag;
   logic [2:0]  frm;
   logic        flush;
   logic [63:0] cvt_operand;
   logic [1:0]  cvt_in_type, cvt_out_type;
   logic [2:0]  cvt_rm;
   logic [31:0] cvt_result;
   logic [3:0]  cvt_flags;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_illegal, rsp_src;
   logic [3:0]  rsp_tag;
   logic [3:0]  fflags;
   logic        fflags_clr;

   fp_convert_sequencer #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_operand(req0_operand), .req0_in_type(req0_in_type),
      .req0_out_type(req0_out_type), .req0_rm(req0_rm),
      .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_operand(req1_operand), .req1_in_type(req1_in_type),
      .req1_out_type(req1_out_type), .req1_rm(req1_rm),
      .req1_tag(req1_tag),
      .frm(frm), .flush(flush),
      .cvt_operand(cvt_operand), .cvt_in_type(cvt_in_type),
      .cvt_out_type(cvt_out_type), .cvt_rm(cvt_rm),
      .cvt_result(cvt_result), .cvt_flags(cvt_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_illegal(rsp_illegal), .rsp_src(rsp_src),
      .rsp_tag(rsp_tag), .fflags(fflags), .fflags_clr(fflags_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] op;
      logic [1:0]  it;
      logic [1:0]  ot;
      logic [2:0]  rm;
      logic [3:0]  tag;
   } req_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      logic        ill;
      logic        src;
      logic [3:0]  tag;
      int          e;
   } exp_t;

   req_t pend0[$];
   req_t pend1[$];
   exp_t mq[$];
   int   acc_log[$];
   int   rsp_src_log[$];
   int   rsp_tag_log[$];
   int   rsp_cyc_log[$];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_pop = -10;
   int   last_acc = 0;
   logic m_rr = 1'b0;
   logic [3:0] m_ff = 4'b0;
   logic took0 = 1'b0;
   logic took1 = 1'b0;

   logic       m_ev, m_acc, m_hs;
   logic [1:0] m_g;
   exp_t       m_new;
   exp_t       m_head;

   // Stand-in converter: two known conversions, else a bit pattern.
   function automatic logic [35:0] conv(
      input logic [63:0] op, input logic [1:0] it,
      input logic [1:0] ot, input logic [2:0] rm
   );
      if (op == 64'h3FF8000000000000 && it == 2'b01 && ot == 2'b10)
         return {32'd2, 4'b0001};
      if (op == 64'h7FF8000000000000 && ot == 2'b10)
         return {32'h80000000, 4'b1000};
      return {op[31:0] ^ {25'd0, it, ot, rm}, op[35:32]};
   endfunction

   always_comb begin
      {cvt_result, cvt_flags} = conv(cvt_operand, cvt_in_type,
                                     cvt_out_type, cvt_rm);
   end

   function automatic exp_t mk(
      input logic [63:0] op, input logic [1:0] it,
      input logic [1:0] ot, input logic [2:0] rm,
      input logic [2:0] f, input logic [3:0] tag,
      input logic src, input int e
   );
      exp_t x;
      logic [2:0] r;
      r = (rm == 3'b111) ? f : rm;
      x.ill = (r > 3'd4) || (ot == 2'b01) || (it == ot);
      if (x.ill) begin
         x.res = 32'd0;
         x.fl  = 4'd0;
      end else begin
         {x.res, x.fl} = conv(op, it, ot, r);
      end
      x.src = src;
      x.tag = tag;
      x.e   = e;
      return x;
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare process: model of in-flight ops, checked every cycle.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         m_ev = 1'b0;
         if (!rst && mq.size() > 0) begin
            m_head = mq[0];
            m_ev = (cyc >= m_head.e) && (cyc >= last_pop + 1);
         end
         m_acc = !rst && !flush && (mq.size() < 2 || rsp_ready);
         if (req0_valid && req1_valid)
            m_g = m_rr ? 2'b10 : 2'b01;
         else
            m_g = {req1_valid, req0_valid};
         chk("rsp_valid", 64'(rsp_valid), 64'(m_ev));
         chk("req0_ready", 64'(req0_ready), 64'(m_acc && m_g[0]));
         chk("req1_ready", 64'(req1_ready), 64'(m_acc && m_g[1]));
         chk("fflags", 64'(fflags), 64'(m_ff));
         if (m_ev && rsp_valid) begin
            chk("rsp_result", 64'(rsp_result), 64'(m_head.res));
            chk("rsp_flags", 64'(rsp_flags), 64'(m_head.fl));
            chk("rsp_illegal", 64'(rsp_illegal), 64'(m_head.ill));
            chk("rsp_src", 64'(rsp_src), 64'(m_head.src));
            chk("rsp_tag", 64'(rsp_tag), 64'(m_head.tag));
         end
         if (rst) begin
            chk("rst_rsp", 64'({rsp_result, rsp_flags, rsp_illegal,
                                rsp_src, rsp_tag}), 64'd0);
         end
         took0 = req0_valid && req0_ready;
         took1 = req1_valid && req1_ready;
         if (rst) begin
            mq.delete();
            m_rr = 1'b0;
            m_ff = 4'b0;
         end else begin
            m_hs = m_ev && rsp_ready;
            m_ff = fflags_clr ? 4'b0 : m_ff;
            if (m_hs) begin
               if (!m_head.ill) m_ff = m_ff | m_head.fl;
               void'(mq.pop_front());
               last_pop = cyc;
               rsp_src_log.push_back(int'(m_head.src));
               rsp_tag_log.push_back(int'(m_head.tag));
               rsp_cyc_log.push_back(cyc);
            end
            if (flush) begin
               mq.delete();
            end else if (m_acc && (|m_g)) begin
               if (m_g[1])
                  m_new = mk(req1_operand, req1_in_type, req1_out_type,
                             req1_rm, frm, req1_tag, 1'b1, cyc + 2);
               else
                  m_new = mk(req0_operand, req0_in_type, req0_out_type,
                             req0_rm, frm, req0_tag, 1'b0, cyc + 2);
               mq.push_back(m_new);
               m_rr = ~m_g[1];
               acc_log.push_back(int'(m_g[1]));
               last_acc = cyc;
            end
         end
      end
   end

   // Requester drivers: present queue heads, hold until taken.
   initial begin
      req0_valid = 0; req0_operand = 0; req0_in_type = 0;
      req0_out_type = 0; req0_rm = 0; req0_tag = 0;
      req1_valid = 0; req1_operand = 0; req1_in_type = 0;
      req1_out_type = 0; req1_rm = 0; req1_tag = 0;
      forever begin
         @(posedge clk);
         #1;
         if (took0 && pend0.size() > 0) void'(pend0.pop_front());
         if (took1 && pend1.size() > 0) void'(pend1.pop_front());
         req0_valid = pend0.size() > 0;
         if (req0_valid) begin
            req0_operand  = pend0[0].op;
            req0_in_type  = pend0[0].it;
            req0_out_type = pend0[0].ot;
            req0_rm       = pend0[0].rm;
            req0_tag      = pend0[0].tag;
         end
         req1_valid = pend1.size() > 0;
         if (req1_valid) begin
            req1_operand  = pend1[0].op;
            req1_in_type  = pend1[0].it;
            req1_out_type = pend1[0].ot;
            req1_rm       = pend1[0].rm;
            req1_tag      = pend1[0].tag;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push0(input logic [63:0] op, input logic [1:0] it,
                        input logic [1:0] ot, input logic [2:0] rm,
                        input logic [3:0] tag);
      req_t r;
      r.op = op; r.it = it; r.ot = ot; r.rm = rm; r.tag = tag;
      pend0.push_back(r);
   endtask

   task automatic push1(input logic [63:0] op, input logic [1:0] it,
                        input logic [1:0] ot, input logic [2:0] rm,
                        input logic [3:0] tag);
      req_t r;
      r.op = op; r.it = it; r.ot = ot; r.rm = rm; r.tag = tag;
      pend1.push_back(r);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         tick();
         if (pend0.size() == 0 && pend1.size() == 0 && mq.size() == 0)
            return;
      end
      checks++;
      failures++;
      $display("FAIL wait_idle: pipeline still busy after 300 cycles");
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_rsp: no response within 50 cycles");
   endtask

   task automatic wait_acc(input int n);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (acc_log.size() >= n) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_acc: no grant within 50 cycles");
   endtask

   int base;
   int nlog;

   initial begin
      rst = 1; rsp_ready = 1; flush = 0; frm = 0; fflags_clr = 0;
      repeat (3) tick();
      rst = 0;

      // Single op: 1.5 to INT32 rounds to 2, inexact.
      push0(64'h3FF8000000000000, 2'b01, 2'b10, 3'b000, 4'd3);
      wait_rsp();
      chk("t1_result", 64'(rsp_result), 64'd2);
      chk("t1_flags", 64'(rsp_flags), 64'h1);
      chk("t1_src", 64'(rsp_src), 64'd0);
      chk("t1_tag", 64'(rsp_tag), 64'd3);
      chk("t1_latency", 64'(cyc - last_acc), 64'd2);
      tick(); tick();
      chk("t1_fflags", 64'(fflags), 64'h1);

      // req1 alone, then both requesters contend.
      push1(64'h0000000200000010, 2'b11, 2'b00, 3'b011, 4'd5);
      wait_idle();
      base = acc_log.size();
      nlog = rsp_src_log.size();
      for (int i = 0; i < 4; i++) begin
         push0(64'(16 * i + 1), 2'b00, 2'b10, 3'b000, 4'(i));
         push1(64'(16 * i + 2), 2'b00, 2'b11, 3'b001, 4'(8 + i));
      end
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         chk("rr_grant", 64'(acc_log[base + i]), 64'(i % 2));
         chk("rr_rsp_src", 64'(rsp_src_log[nlog + i]), 64'(i % 2));
         chk("rr_rsp_tag", 64'(rsp_tag_log[nlog + i]),
             64'((i % 2) * 8 + i / 2));
      end
      chk("rr_rate", 64'(rsp_cyc_log[nlog + 7] - rsp_cyc_log[nlog]),
          64'd7);

      // Dynamic rounding resolves through frm.
      frm = 3'b011;
      base = acc_log.size();
      push0(64'h400921FB54442D18, 2'b01, 2'b00, 3'b111, 4'd6);
      wait_acc(base + 1);
      @(negedge clk);
      #1;
      chk("dyn_cvt_rm", 64'(cvt_rm), 64'h3);
      wait_idle();
      frm = 3'b101;
      push0(64'h4000000000000000, 2'b01, 2'b10, 3'b111, 4'd7);
      wait_rsp();
      chk("badfrm_ill", 64'(rsp_illegal), 64'd1);
      chk("badfrm_res", 64'(rsp_result), 64'd0);
      wait_idle();
      frm = 3'b000;
      push0(64'h0000000F40000000, 2'b01, 2'b10, 3'b110, 4'd8);
      wait_rsp();
      chk("badrm_ill", 64'(rsp_illegal), 64'd1);
      chk("badrm_flags", 64'(rsp_flags), 64'd0);
      wait_idle();
      base = acc_log.size();
      push0(64'h0000000C00000001, 2'b00, 2'b01, 3'b000, 4'd9);
      wait_acc(base + 1);
      @(negedge clk);
      #1;
      chk("ill_cvt_rm", 64'(cvt_rm), 64'h1);
      wait_idle();
      push1(64'h0000000C00000002, 2'b10, 2'b10, 3'b000, 4'd10);
      wait_idle();

      // Backpressure fills both stages.
      rsp_ready = 0;
      for (int i = 1; i <= 5; i++)
         push0(64'(i * 3), 2'b00, 2'b10, 3'b000, 4'(i));
      repeat (3) tick();
      @(negedge clk);
      #1;
      chk("bp_ready", 64'(req0_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_tag", 64'(rsp_tag), 64'd1);
      tick(); tick();
      rsp_ready = 1;
      wait_idle();

      // NaN converts to the INT32 invalid value.
      push0(64'h7FF8000000000000, 2'b01, 2'b10, 3'b000, 4'd9);
      wait_rsp();
      chk("nan_result", 64'(rsp_result), 64'h80000000);
      chk("nan_flags", 64'(rsp_flags), 64'h8);
      wait_idle();
      chk("nan_nv", 64'(fflags[3]), 64'd1);

      // Clear coincides with a retiring op.
      rsp_ready = 0;
      push0(64'h0000000112345678, 2'b01, 2'b11, 3'b000, 4'd10);
      wait_rsp();
      tick();
      rsp_ready = 1;
      fflags_clr = 1;
      tick();
      fflags_clr = 0;
      @(negedge clk);
      #1;
      chk("clr_fflags", 64'(fflags), 64'h1);
      wait_idle();

      // Flush with both stages full.
      rsp_ready = 0;
      nlog = rsp_src_log.size();
      for (int i = 0; i < 3; i++)
         push0(64'(100 + i), 2'b00, 2'b10, 3'b000, 4'(i));
      repeat (4) tick();
      flush = 1;
      tick();
      flush = 0;
      tick();
      rsp_ready = 1;
      wait_idle();
      chk("flush_count", 64'(rsp_src_log.size() - nlog), 64'd1);

      // Flush in the same cycle as a retire.
      nlog = rsp_src_log.size();
      base = acc_log.size();
      push0(64'h0000000400000050, 2'b00, 2'b10, 3'b000, 4'd4);
      push0(64'h0000000000000060, 2'b00, 2'b10, 3'b000, 4'd5);
      wait_acc(base + 1);
      tick(); tick();
      flush = 1;
      tick();
      flush = 0;
      wait_idle();
      chk("flush_hs_count", 64'(rsp_src_log.size() - nlog), 64'd1);
      chk("flush_hs_fflags", 64'(fflags), 64'h5);

      // Reset in the middle of traffic.
      for (int i = 0; i < 3; i++) begin
         push0(64'(200 + i), 2'b00, 2'b10, 3'b000, 4'(i));
         push1(64'(300 + i), 2'b00, 2'b11, 3'b000, 4'(4 + i));
      end
      repeat (3) tick();
      rst = 1;
      tick();
      pend0.delete();
      pend1.delete();
      tick();
      rst = 0;
      @(negedge clk);
      #1;
      chk("post_rst_cvt", cvt_operand, 64'd0);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_result", 64'(rsp_result), 64'd0);
      chk("post_rst_fflags", 64'(fflags), 64'd0);
      tick();
      base = acc_log.size();
      nlog = rsp_src_log.size();
      push0(64'h0000000200000070, 2'b00, 2'b10, 3'b000, 4'd12);
      push1(64'h0000000000000071, 2'b00, 2'b11, 3'b000, 4'd13);
      wait_idle();
      chk("rst_first_grant", 64'(acc_log[base]), 64'd0);
      chk("rst_rsp0_tag", 64'(rsp_tag_log[nlog]), 64'd12);
      chk("rst_rsp1_tag", 64'(rsp_tag_log[nlog + 1]), 64'd13);
      chk("rst_fflags", 64'(fflags), 64'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fp_convert_sequencer.md
Name: fp_convert_sequencer

Overview:
- Front-end controller for the shared combinational FP64 converter (FP64 -> FP32/INT32/UINT32).
- Arbitrates two requesters (req0 = FP issue, req1 = integer issue) round-robin and resolves dynamic rounding mode.
- Registers the operation, then captures result and flags with valid/ready backpressure.
- Accumulates sticky exception flags (fflags) for the CSR file.

Parameters:
- TAG_W, 4, width of the requester tag returned with each response.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- reqN_valid  in  1  request valid, N = 0,1
- reqN_ready  out  1  request accepted this cycle when valid && ready
- reqN_operand  in  64  source bits (FP64, or FP32/int in [31:0])
- reqN_in_type  in  2  00 FP32, 01 FP64, 10 INT32, 11 UINT32
- reqN_out_type  in  2  same encoding
- reqN_rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 111 DYN
- reqN_tag  in  TAG_W  opaque tag
- frm  in  3  CSR rounding mode, used when rm = DYN
- flush  in  1  discard all in-flight operations
- cvt_operand  out  64  to converter
- cvt_in_type  out  2  to converter
- cvt_out_type  out  2  to converter
- cvt_rm  out  3  to converter (resolved mode)
- cvt_result  in  32  from converter
- cvt_flags  in  4  from converter {nv, of, uf, nx}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_result  out  32  converted value
- rsp_flags  out  4  {nv, of, uf, nx} for this op
- rsp_illegal  out  1  op rejected (bad rm / type pair)
- rsp_src  out  1  0 = req0, 1 = req1
- rsp_tag  out  TAG_W  echoed tag
- fflags  out  4  sticky accumulated flags
- fflags_clr  in  1  clear sticky flags

Behaviour:
- Two-stage pipeline: stage A (issue register) drives cvt_*; stage B (response register) drives rsp_*.
- Latency: request handshake in cycle t -> rsp_valid in cycle t+2.
- Throughput: 1 op/cycle while rsp_ready = 1.
- Advance rules:
  - B_load = A_valid && (!B_valid || rsp_ready).
  - A_accept = !A_valid || B_load.
- Arbitration (round-robin, pointer rr):
  - If both requesters valid, grant req[rr]. After the grant, rr <= ~granted_index.
  - A single valid requester is granted regardless of rr.
  - reqN_ready = A_accept && grantN. ready never asserts for a non-granted requester. Ready is combinational from valid and state; a requester must not make valid depend on ready.
- Rounding resolution at capture into A:
  - rm = 111 uses frm; else rm.
  - Resolved value 101/110/111 -> illegal.
- Type legality:
  - Illegal if out_type = FP64 (32-bit result path) or in_type = out_type.
  - Illegal op: cvt_* driven with stored values but cvt_rm = RTZ. Stage B stores result 0, flags 0, illegal 1.
- Stage B capture on B_load: result, flags (0 if illegal), illegal, src, tag.
- Stage B holds all rsp_* stable while rsp_valid && !rsp_ready.
- When A is empty, cvt_* = 0.
- Sticky flags: fflags_next = (fflags_clr ? 0 : fflags) | ((rsp_valid && rsp_ready && !rsp_illegal) ? rsp_flags : 0). Clear and a same-cycle handshake leave only the new flags.
- flush:
  - Next cycle A_valid = B_valid = 0; no response is emitted for flushed ops.
  - reqN_ready = 0 during the flush cycle.
  - fflags and rr are unchanged.
- Reset (also mid-operation):
  - A_valid, B_valid, rr, fflags all 0.
  - rsp_* = 0 and reqN_ready = 0 in the reset cycle.
  - First grant is possible in the cycle after rst deasserts.
- Simultaneous flush and rsp handshake: the handshake completes and its flags merge; then the pipeline empties.

Decomposition:
- Package fp_cvt_pkg:
  - type codes (FP32/FP64/INT32/UINT32);
  - RM codes incl. DYN = 3'b111;
  - flag bit indices NV=3, OF=2, UF=1, NX=0;
  - rm-resolve and legality functions.
- Sub-module fp_cvt_rr_arb2: 2-input round-robin arbiter (req[1:0], advance, gnt[1:0], rr state).

Test Plan:
- req0: operand 64'h3FF8000000000000 (1.5), FP64->INT32, rm RNE; cvt_result 2, flags 4'b0001 -> rsp_result 2, rsp_flags 0001, rsp_src 0, rsp_valid at t+2, fflags 0001.
- req0 and req1 both valid for 4 cycles with rsp_ready = 1 -> grant order 0,1,0,1; responses return in order with matching tags; one per cycle.
- rm = DYN with frm = 011 -> cvt_rm = 011. rm = DYN with frm = 101, or rm = 110 -> rsp_illegal 1, result 0, fflags unchanged.
- rsp_ready held 0 for 3 cycles with a continuous req0 stream -> stage A and B fill; req0_ready drops to 0; rsp_* stable; no loss or duplication after release.
- NaN input 64'h7FF8000000000000 -> INT32 (cvt_result 32'h80000000, flags 1000), then fflags_clr in the handshake cycle of a second op with flags 0001 -> fflags = 0001.
- flush with both stages full, and rst asserted mid-stream -> no responses for flushed ops; all outputs 0 after reset; next accepted op completes normally with rr = 0.
